// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one command byte to a PS/2 device over the shared open-drain
// clock/data pins. The device generates the clock. This block only pulls a
// line low or releases it. Frame sequence:
//   inhibit (clock low) -> request-to-send (data low, clock low)
//   -> release clock, shift 8 data bits + odd parity + stop on device falls
//   -> sample the device ACK on the 11th fall -> wait for bus idle -> done.
//
// Ports:
//   clock_i               system clock
//   rst_ni                asynchronous reset, active low
//   tx_valid_i            request to send tx_data_i
//   tx_data_i[7:0]        command byte
//   tx_ready_o            high when a new byte can be accepted (IDLE)
//   ps2_clock_in_i        PS/2 clock pin as seen on the bus
//   ps2_data_in_i         PS/2 data pin as seen on the bus
//   ps2_clock_drv_low_o   1 = pull PS/2 clock low, 0 = release
//   ps2_data_drv_low_o    1 = pull PS/2 data low, 0 = release
//   busy_o                inverse of tx_ready_o
//   done_o                one-cycle pulse at the end of every accepted frame
//   ack_ok_o              device acknowledged the frame
//   err_noack_o           data was high at the 11th falling edge
//   err_timeout_o         device did not finish clocking in time
//   (status flags are valid from done_o until the next accept)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clock_i,
  input  logic       rst_ni,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  input  logic       ps2_clock_in_i,
  input  logic       ps2_data_in_i,
  output logic       ps2_clock_drv_low_o,
  output logic       ps2_data_drv_low_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_ok_o,
  output logic       err_noack_o,
  output logic       err_timeout_o
);

  // One shared cycle counter serves inhibit, setup and timeout phases.
  localparam int MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam int FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  // ---------------------------------------------------------------------
  // Input path: 2-flop synchroniser then a run-length filter per pin.
  // Index 0 = clock pin, index 1 = data pin.
  // ---------------------------------------------------------------------
  logic [1:0] pin_raw;
  logic [1:0] pin_filt;

  assign pin_raw = {ps2_data_in_i, ps2_clock_in_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_pin
    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;

    // The filtered value flips only after FILTER_LEN consecutive samples
    // disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge clock_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        filt_q  <= 1'b1;
        fcnt_q  <= '0;
      end else begin
        sync1_q <= pin_raw[gi];
        sync2_q <= sync1_q;
        if (sync2_q == filt_q) begin
          fcnt_q <= '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q <= sync2_q;
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end
    end

    assign pin_filt[gi] = filt_q;
  end

  logic clk_filt;
  logic dat_filt;
  logic clk_prev_q;
  logic fall;

  assign clk_filt = pin_filt[0];
  assign dat_filt = pin_filt[1];
  assign fall     = clk_prev_q & ~clk_filt;

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) clk_prev_q <= 1'b1;
    else         clk_prev_q <= clk_filt;
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          data_low_q, data_low_d;
  logic          done_q, done_d;
  logic          ack_ok_q, ack_ok_d;
  logic          noack_q, noack_d;
  logic          tmo_q, tmo_d;
  logic          accept;

  assign accept = tx_valid_i & tx_ready_o;

  // State and datapath registers.
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      data_low_q <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      noack_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      data_low_q <= data_low_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
      noack_q    <= noack_d;
      tmo_q      <= tmo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    data_low_d = data_low_q;
    done_d     = 1'b0;
    ack_ok_d   = ack_ok_q;
    noack_d    = noack_q;
    tmo_d      = tmo_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d    = S_INHIBIT;
          shift_d    = {1'b1, ~^tx_data_i, tx_data_i};
          bit_cnt_d  = '0;
          data_low_d = 1'b0;
          ack_ok_d   = 1'b0;
          noack_d    = 1'b0;
          tmo_d      = 1'b0;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          state_d = S_RTS;
          cnt_d   = '0;
        end
      end

      S_RTS: begin
        if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
          state_d    = S_SEND;
          cnt_d      = '0;
          data_low_d = 1'b1;  // start bit stays on the wire until fall 1
        end
      end

      S_SEND: begin
        if (fall && bit_cnt_q == 4'd10) begin
          // Fall 11: device drives the ACK bit.
          bit_cnt_d = 4'd11;
          ack_ok_d  = ~dat_filt;
          noack_d   = dat_filt;
          state_d   = S_WAIT_IDLE;
        end else if (cnt_q >= CW'(TIMEOUT_CYCLES - 1)) begin
          state_d    = S_IDLE;
          data_low_d = 1'b0;
          tmo_d      = 1'b1;
          done_d     = 1'b1;
        end else if (fall) begin
          // Data changes only here, right after a falling edge.
          data_low_d = ~shift_q[0];
          shift_d    = {1'b0, shift_q[9:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
        end
      end

      S_WAIT_IDLE: begin
        cnt_d      = '0;
        data_low_d = 1'b0;
        if (clk_filt && dat_filt) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        cnt_d      = '0;
        data_low_d = 1'b0;
      end
    endcase
  end

  // Outputs. The done cycle itself is not ready, so a held tx_valid is
  // accepted on the cycle after done.
  always_comb begin
    tx_ready_o          = (state_q == S_IDLE) && !done_q;
    busy_o              = ~tx_ready_o;
    ps2_clock_drv_low_o = (state_q == S_INHIBIT) || (state_q == S_RTS);
    ps2_data_drv_low_o  = (state_q == S_RTS) || ((state_q == S_SEND) && data_low_q);
    done_o              = done_q;
    ack_ok_o            = ack_ok_q;
    err_noack_o         = noack_q;
    err_timeout_o       = tmo_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: directed frames against a PS/2 device model,
// with a scoreboard queue checked by a monitor on every done pulse.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, clk_drv, dat_drv, busy, done, ack_ok, err_noack, err_timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       glitch = 1'b0;
  logic       ps2_clk_pin, ps2_dat_pin;

  // Open-drain wired-AND bus with pull-ups.
  assign ps2_clk_pin = ~(clk_drv | dev_clk_low | glitch);
  assign ps2_dat_pin = ~(dat_drv | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(10),
    .SETUP_CYCLES  (2),
    .TIMEOUT_CYCLES(2000),
    .FILTER_LEN    (2)
  ) dut (
    .clock_i            (clk),
    .rst_ni             (rst_n),
    .tx_valid_i         (tx_valid),
    .tx_data_i          (tx_data),
    .tx_ready_o         (tx_ready),
    .ps2_clock_in_i     (ps2_clk_pin),
    .ps2_data_in_i      (ps2_dat_pin),
    .ps2_clock_drv_low_o(clk_drv),
    .ps2_data_drv_low_o (dat_drv),
    .busy_o             (busy),
    .done_o             (done),
    .ack_ok_o           (ack_ok),
    .err_noack_o        (err_noack),
    .err_timeout_o      (err_timeout)
  );

  typedef struct {
    logic [7:0]  data;
    logic [10:0] bits;      // {stop, parity, d7..d0, start} as read by the device
    bit          chk_bits;
    bit          ack;
    bit          noack;
    bit          tmo;
    int          latency;   // cycles from clock release to done, -1 = unchecked
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          release_cyc = 0;
  logic        prev_clk_drv = 1'b0;
  logic [10:0] seen_bits = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [10:0] b, input bit cb,
                      input bit a, input bit na, input bit t, input int lat);
    exp_t e;
    e.data = d; e.bits = b; e.chk_bits = cb;
    e.ack = a; e.noack = na; e.tmo = t; e.latency = lat;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (prev_clk_drv && !clk_drv) release_cyc = cyc;
    prev_clk_drv = clk_drv;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, required no frame pending");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("frame %02h: ack_ok=%0d err_noack=%0d err_timeout=%0d wire=%011b",
                 e.data, ack_ok, err_noack, err_timeout, seen_bits);
        chk("ack_ok", int'(ack_ok), int'(e.ack));
        chk("err_noack", int'(err_noack), int'(e.noack));
        chk("err_timeout", int'(err_timeout), int'(e.tmo));
        chk("clk_released_at_done", int'(clk_drv), 0);
        chk("data_released_at_done", int'(dat_drv), 0);
        if (e.chk_bits) chk("wire_bits", int'(seen_bits), int'(e.bits));
        if (e.latency >= 0) chk("timeout_latency", cyc - release_cyc, e.latency);
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge clk); n++; end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin @(negedge clk); n++; end
    chk("done_seen", int'(done), 1);
  endtask

  // Device model: watches inhibit/RTS, then clocks 11 pulses (half-period 10),
  // reading data at each rising edge. abort_k > 0 stops after that fall with
  // the device clock still low. inject adds a stray tx_valid and a clock glitch.
  task automatic dev_frame(input bit do_ack, input int abort_k, input bit inject);
    int n;
    n = 0;
    while (!clk_drv && n < 100) begin @(negedge clk); n++; end
    chk("inhibit_start", int'(clk_drv), 1);
    if (!clk_drv) return;
    n = 0;
    while (clk_drv && !dat_drv && n < 100) begin n++; @(negedge clk); end
    chk("inhibit_len", n, 10);
    n = 0;
    while (clk_drv && n < 100) begin n++; @(negedge clk); end
    chk("rts_len", n, 2);
    repeat (5) @(negedge clk);
    seen_bits[0] = ps2_dat_pin;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) dev_dat_low = do_ack;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      if (inject && k == 3) begin
        repeat (3) @(negedge clk);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);
      end else begin
        repeat (10) @(negedge clk);
      end
      if (abort_k == k) return;
      dev_clk_low = 1'b0;
      if (k <= 10) seen_bits[k] = ps2_dat_pin;
      if (inject && k == 5) begin
        repeat (2) @(negedge clk);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
    end
    dev_dat_low = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_clk_drv", int'(clk_drv), 0);
    chk("rst_dat_drv", int'(dat_drv), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flags", int'({ack_ok, err_noack, err_timeout}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. 0xED acknowledged.
    push(8'hED, 11'b1_1_11101101_0, 1, 1, 0, 0, -1);
    send(8'hED);
    dev_frame(1'b1, 0, 1'b0);
    wait_done(200);

    // 2. 0xF4 not acknowledged; parity 0.
    push(8'hF4, 11'b1_0_11110100_0, 1, 0, 1, 0, -1);
    send(8'hF4);
    dev_frame(1'b0, 0, 1'b0);
    wait_done(200);

    // 3. 0xFF, device never clocks.
    push(8'hFF, 11'b0, 0, 0, 0, 1, 2000);
    send(8'hFF);
    wait_done(3000);

    // 4. Reset after fall 4 of 0xAA, then 0x00.
    send(8'hAA);
    dev_frame(1'b1, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_clk_drv", int'(clk_drv), 0);
    chk("abort_dat_drv", int'(dat_drv), 0);
    chk("abort_done", int'(done), 0);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(tx_ready), 1);
    push(8'h00, 11'b1_1_00000000_0, 1, 1, 0, 0, -1);
    send(8'h00);
    dev_frame(1'b1, 0, 1'b0);
    wait_done(200);

    // 5. Stray tx_valid (0x12) and clock glitch during 0xED.
    push(8'hED, 11'b1_1_11101101_0, 1, 1, 0, 0, -1);
    send(8'hED);
    dev_frame(1'b1, 0, 1'b1);
    wait_done(200);
    repeat (40) @(negedge clk);
    chk("stray_not_queued_clk", int'(clk_drv), 0);
    chk("stray_not_queued_ready", int'(tx_ready), 1);

    // 6. Back-to-back with tx_valid held; tx_data change mid-frame.
    push(8'h55, 11'b1_1_01010101_0, 1, 1, 0, 0, -1);
    push(8'h3C, 11'b1_1_00111100_0, 1, 1, 0, 0, -1);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h3C;
    dev_frame(1'b1, 0, 1'b0);
    wait_done(200);
    chk("b2b_ready_in_done", int'(tx_ready), 0);
    @(negedge clk);
    chk("b2b_ready_after_done", int'(tx_ready), 1);
    @(negedge clk);
    chk("b2b_accepted", int'(clk_drv), 1);
    tx_valid = 1'b0;
    dev_frame(1'b1, 0, 1'b0);
    wait_done(200);
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
